// File: rtl/debug_port_pkg.sv
// Shared register map, bit positions and helpers for the multi-channel debug output port.
package debug_port_pkg;

  localparam int ENTRY_W = 36;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;
  localparam int ST_EN    = 11;

  localparam int CTL_EN    = 0;
  localparam int CTL_CLR   = 1;
  localparam int CTL_FLUSH = 2;

  typedef enum logic {ARB_IDLE, ARB_PRESENT} arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Round-robin pick: first set bit of avail strictly after last, wrapping within n channels.
  function automatic pick_t rr_pick(input logic [7:0] avail, input logic [2:0] last, input int n);
    pick_t r;
    int    c;
    r = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= n && !r.found) begin
        c = (int'(last) + k) % n;
        if (avail[c[2:0]]) begin
          r.found = 1'b1;
          r.idx   = c[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/debug_port_fifo.sv
// Per-channel write FIFO; head and the entry behind it are read combinationally from storage.
module debug_port_fifo
  import debug_port_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] data,
  output logic               full,
  output logic               empty,
  output logic [7:0]         level,
  output logic [ENTRY_W-1:0] head,
  output logic [ENTRY_W-1:0] head_next
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [AW:0]        count;
  logic               do_pop;
  logic               do_push;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign level     = 8'(count);
  assign head      = mem[rd_ptr[AW-1:0]];
  // Lets the arbiter re-present the same channel on the cycle its head is popped.
  assign head_next = mem[rd_ptr[AW-1:0] + AW'(1)];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/debug_port.sv
// Memory-mapped multi-channel debug output: per-channel FIFOs drained by a round-robin stream arbiter.
module debug_port
  import debug_port_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 8,
  parameter int CH_BITS  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cs,
  input  logic               read,
  input  logic               write,
  input  logic [13:0]        low_address,
  input  logic [31:0]        data_in,
  input  logic [3:0]         data_strobes,
  output logic [31:0]        data_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_BITS-1:0] out_channel,
  output logic [31:0]        out_data,
  output logic [3:0]         out_strobes,
  output logic               irq
);

  logic [2:0] ch_sel;
  logic [1:0] reg_sel;
  logic       bus_wr;
  logic       bus_rd;
  logic       unused_addr;

  assign ch_sel      = low_address[4:2];
  assign reg_sel     = low_address[1:0];
  assign unused_addr = ^low_address[13:5];
  assign bus_wr      = cs && write;
  assign bus_rd      = cs && read && !write;

  logic [CHANNELS-1:0] enable, overflow, push_req, ctl_wr, flush, pop;
  logic [CHANNELS-1:0] fifo_full, fifo_empty;
  logic [7:0]          fifo_level     [CHANNELS];
  logic [ENTRY_W-1:0]  fifo_head      [CHANNELS];
  logic [ENTRY_W-1:0]  fifo_head_next [CHANNELS];
  logic [ENTRY_W-1:0]  entry_in;

  arb_state_t          state;
  logic [2:0]          last_served;

  assign entry_in = {data_strobes, data_in};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic en_q;
    logic ovf_q;

    assign push_req[i] = bus_wr && (ch_sel == 3'(i)) && (reg_sel == REG_DATA)
                         && en_q && (|data_strobes);
    assign ctl_wr[i]   = bus_wr && (ch_sel == 3'(i)) && (reg_sel == REG_CONTROL)
                         && data_strobes[0];
    assign flush[i]    = ctl_wr[i] && data_in[CTL_FLUSH];
    // A flush of the presented channel cancels the handshake on the same edge.
    assign pop[i]      = (state == ARB_PRESENT) && out_valid && out_ready
                         && (out_channel == CH_BITS'(i)) && !flush[i];
    assign enable[i]   = en_q;
    assign overflow[i] = ovf_q;

    debug_port_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_req[i] && !flush[i]),
      .pop       (pop[i]),
      .flush     (flush[i]),
      .data      (entry_in),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i]),
      .level     (fifo_level[i]),
      .head      (fifo_head[i]),
      .head_next (fifo_head_next[i])
    );

    always_ff @(posedge clock) begin
      if (reset) begin
        en_q  <= 1'b1;
        ovf_q <= 1'b0;
      end else begin
        if (ctl_wr[i]) en_q <= data_in[CTL_EN];
        if (ctl_wr[i] && data_in[CTL_CLR]) ovf_q <= 1'b0;
        else if (push_req[i] && fifo_full[i] && !pop[i] && !flush[i]) ovf_q <= 1'b1;
      end
    end
  end

  logic [7:0]         avail_idle;
  logic [7:0]         avail_next;
  pick_t              pick_idle;
  pick_t              pick_next;
  logic [ENTRY_W-1:0] sel_idle;
  logic [ENTRY_W-1:0] sel_next;
  logic               present_flush;

  always_comb begin
    avail_idle    = '0;
    avail_next    = '0;
    present_flush = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      avail_idle[i] = !fifo_empty[i] && !flush[i];
      // The presented channel loses the entry being popped this cycle.
      avail_next[i] = avail_idle[i] &&
                      !((out_channel == CH_BITS'(i)) && (fifo_level[i] == 8'd1));
      if (flush[i] && (out_channel == CH_BITS'(i))) present_flush = 1'b1;
    end
    pick_idle = rr_pick(avail_idle, last_served, CHANNELS);
    pick_next = rr_pick(avail_next, last_served, CHANNELS);
    sel_idle  = '0;
    sel_next  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pick_idle.idx == 3'(i)) sel_idle = fifo_head[i];
      if (pick_next.idx == 3'(i))
        sel_next = (out_channel == CH_BITS'(i)) ? fifo_head_next[i] : fifo_head[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB_IDLE;
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_data    <= '0;
      out_strobes <= '0;
      last_served <= 3'(CHANNELS - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_idle.found) begin
            state       <= ARB_PRESENT;
            out_valid   <= 1'b1;
            out_channel <= CH_BITS'(pick_idle.idx);
            out_strobes <= sel_idle[35:32];
            out_data    <= sel_idle[31:0];
            last_served <= pick_idle.idx;
          end
        end
        ARB_PRESENT: begin
          if (present_flush) begin
            state     <= ARB_IDLE;
            out_valid <= 1'b0;
          end else if (out_ready) begin
            if (pick_next.found) begin
              out_channel <= CH_BITS'(pick_next.idx);
              out_strobes <= sel_next[35:32];
              out_data    <= sel_next[31:0];
              last_served <= pick_next.idx;
            end else begin
              state     <= ARB_IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ARB_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == 3'(i)) begin
        if (reg_sel == REG_STATUS) begin
          rd_word[7:0]      = fifo_level[i];
          rd_word[ST_EMPTY] = fifo_empty[i];
          rd_word[ST_FULL]  = fifo_full[i];
          rd_word[ST_OVF]   = overflow[i];
          rd_word[ST_EN]    = enable[i];
        end else if (reg_sel == REG_CONTROL) begin
          rd_word[CTL_EN]   = enable[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out <= '0;
      irq      <= 1'b0;
    end else begin
      if (bus_rd) data_out <= rd_word;
      irq <= |(overflow & enable);
    end
  end

endmodule

// File: tb/tb_debug_port.sv
// Directed bench for debug_port: bus register access, drain ordering, back-pressure, flush and reset.
module tb_debug_port;

  logic        clock = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [13:0] low_address;
  logic [31:0] data_in;
  logic [3:0]  data_strobes;
  logic [31:0] data_out;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_channel;
  logic [31:0] out_data;
  logic [3:0]  out_strobes;
  logic        irq;

  int checks = 0;
  int errors = 0;

  debug_port #(.CHANNELS(2), .DEPTH(8), .CH_BITS(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .cs           (cs),
    .read         (read),
    .write        (write),
    .low_address  (low_address),
    .data_in      (data_in),
    .data_strobes (data_strobes),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_channel  (out_channel),
    .out_data     (out_data),
    .out_strobes  (out_strobes),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input int ch, input int rg, input logic [31:0] d, input logic [3:0] s);
    @(negedge clock);
    cs = 1'b1; write = 1'b1; read = 1'b0;
    low_address  = 14'((ch << 2) | rg);
    data_in      = d;
    data_strobes = s;
    @(negedge clock);
    cs = 1'b0; write = 1'b0; data_strobes = 4'b0000;
  endtask

  task automatic bus_read(input int ch, input int rg, output logic [31:0] d);
    @(negedge clock);
    cs = 1'b1; read = 1'b1; write = 1'b0;
    low_address = 14'((ch << 2) | rg);
    @(negedge clock);
    cs = 1'b0; read = 1'b0;
    d = data_out;
  endtask

  logic [31:0] rd;

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    low_address = '0; data_in = '0; data_strobes = '0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check_eq("rst_valid",   out_valid,   0);
    check_eq("rst_channel", out_channel, 0);
    check_eq("rst_data",    out_data,    0);
    check_eq("rst_strobes", out_strobes, 0);
    check_eq("rst_irq",     irq,         0);
    check_eq("rst_dout",    data_out,    0);
    bus_read(0, 1, rd); check_eq("rst_status0", rd, 32'h0000_0900);
    bus_read(1, 1, rd); check_eq("rst_status1", rd, 32'h0000_0900);
    bus_read(1, 2, rd); check_eq("rst_ctrl1",   rd, 32'h0000_0001);

    // Single word through ch0
    out_ready = 1'b1;
    bus_write(0, 0, 32'h1122_3344, 4'b1111);
    check_eq("t1_valid_early", out_valid, 0);
    @(negedge clock);
    check_eq("t1_valid",   out_valid,   1);
    check_eq("t1_channel", out_channel, 0);
    check_eq("t1_data",    out_data,    32'h1122_3344);
    check_eq("t1_strobes", out_strobes, 4'b1111);
    @(negedge clock);
    check_eq("t1_valid_done", out_valid, 0);
    bus_read(0, 1, rd); check_eq("t1_status0", rd, 32'h0000_0900);

    // Overflow on ch1 with the sink stalled
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) bus_write(1, 0, 32'h100 + k, 4'b1111);
    bus_read(1, 1, rd); check_eq("t2_status_full", rd, 32'h0000_0E08);
    check_eq("t2_irq", irq, 1);
    @(negedge clock);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq("t2_drain_valid", out_valid,   1);
      check_eq("t2_drain_ch",    out_channel, 1);
      check_eq("t2_drain_data",  out_data,    32'h100 + k);
      @(negedge clock);
    end
    check_eq("t2_drain_end", out_valid, 0);
    bus_read(1, 1, rd); check_eq("t2_status_ovf", rd, 32'h0000_0D00);
    bus_write(1, 2, 32'h3, 4'b0001);
    bus_read(1, 1, rd); check_eq("t2_status_clr", rd, 32'h0000_0900);
    check_eq("t2_irq_clr", irq, 0);

    // Round-robin interleave, one transfer per cycle
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_write(0, 0, 32'hA00 + k, 4'b1111);
      bus_write(1, 0, 32'hB00 + k, 4'b1111);
    end
    @(negedge clock);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check_eq("t3_valid", out_valid,   1);
      check_eq("t3_ch",    out_channel, 3'(k % 2));
      check_eq("t3_data",  out_data,    ((k % 2) == 0) ? 32'hA00 + k / 2 : 32'hB00 + k / 2);
      @(negedge clock);
    end
    check_eq("t3_end", out_valid, 0);

    // Back-pressure hold, then flush of the presented channel
    out_ready = 1'b0;
    bus_write(0, 0, 32'hCAFE_0001, 4'b0011);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      check_eq("t4_hold_valid", out_valid,   1);
      check_eq("t4_hold_ch",    out_channel, 0);
      check_eq("t4_hold_data",  out_data,    32'hCAFE_0001);
      check_eq("t4_hold_strb",  out_strobes, 4'b0011);
      @(negedge clock);
    end
    bus_write(0, 2, 32'h5, 4'b0001);
    check_eq("t4_flush_valid", out_valid, 0);
    bus_read(0, 1, rd); check_eq("t4_flush_status", rd, 32'h0000_0900);

    // Disabled channel, zero strobes, control strobe gating
    bus_write(1, 2, 32'h0, 4'b0001);
    bus_write(1, 0, 32'hDEAD_BEEF, 4'b1111);
    bus_read(1, 1, rd); check_eq("t5_disabled", rd, 32'h0000_0100);
    check_eq("t5_disabled_valid", out_valid, 0);
    bus_write(1, 2, 32'h1, 4'b0001);
    bus_write(1, 0, 32'h1234_5678, 4'b0000);
    bus_read(1, 1, rd); check_eq("t5_zero_strb", rd, 32'h0000_0900);
    check_eq("t5_zero_strb_valid", out_valid, 0);
    bus_write(1, 2, 32'h0, 4'b1110);
    bus_read(1, 2, rd); check_eq("t5_ctrl_strb0", rd, 32'h0000_0001);

    // Out-of-range channel reads
    bus_read(0, 1, rd); check_eq("t6_status0", rd, 32'h0000_0900);
    bus_read(5, 1, rd); check_eq("t6_ch5", rd, 32'h0);

    // Reset while an entry is presented
    bus_write(1, 0, 32'h5555_0001, 4'b1111);
    bus_write(0, 0, 32'h5555_0002, 4'b1111);
    bus_write(0, 0, 32'h5555_0003, 4'b1111);
    check_eq("t7_pre_valid", out_valid,   1);
    check_eq("t7_pre_ch",    out_channel, 1);
    bus_read(0, 1, rd); check_eq("t7_pre_status0", rd, 32'h0000_0802);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("t7_valid",   out_valid,   0);
    check_eq("t7_channel", out_channel, 0);
    check_eq("t7_data",    out_data,    0);
    check_eq("t7_strobes", out_strobes, 0);
    check_eq("t7_dout",    data_out,    0);
    check_eq("t7_irq",     irq,         0);
    bus_read(0, 1, rd); check_eq("t7_status0", rd, 32'h0000_0900);
    bus_read(1, 1, rd); check_eq("t7_status1", rd, 32'h0000_0900);
    check_eq("t7_post_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
